mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates an instruction-fetch port and a load/store port
// onto a single memory port with one outstanding transfer and a wait timeout.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; without
// it the load/store port has fixed priority over fetch.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER_IF = 2'd1,
        XFER_LS = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Abort fires on the edge where the wait count would reach TIMEOUT.
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] wait_cnt_reg;
    logic        run_reg;      // low until the first clock edge after reset release
    logic        sel_ls;
    logic        sel_if;
    logic        in_xfer;
    logic        xfer_ack;
    logic        xfer_abort;
    logic [31:0] result_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_ls_reg;

    // On contention grant the port that did not own the previous transfer
    always_comb begin
        sel_ls = ls_req && (!if_req || !last_owner_ls_reg);
    end

    // Track which port received the most recent grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_ls_reg <= 1'b1;
        end else if (ls_gnt) begin
            last_owner_ls_reg <= 1'b1;
        end else if (if_gnt) begin
            last_owner_ls_reg <= 1'b0;
        end
    end
`else
    // Load/store always wins over fetch
    always_comb begin
        sel_ls = ls_req;
    end
`endif

    assign sel_if      = if_req && !sel_ls;
    assign in_xfer     = (state_reg == XFER_IF) || (state_reg == XFER_LS);
    assign mem_req     = in_xfer;
    assign busy        = (state_reg != IDLE);
    assign result_data = xfer_ack ? mem_rdata : ABORT_DATA;

    // State register; reset drops any transfer in flight without a response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    // Next state, combinational grants and transfer-completion decode
    always_comb begin
        state_next = state_reg;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        xfer_ack   = 1'b0;
        xfer_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run_reg) begin
                    if (sel_ls) begin
                        ls_gnt     = 1'b1;
                        state_next = XFER_LS;
                    end else if (sel_if) begin
                        if_gnt     = 1'b1;
                        state_next = XFER_IF;
                    end
                end
            end
            XFER_IF, XFER_LS: begin
                // An ack in the timeout cycle still completes normally.
                if (mem_ack) begin
                    xfer_ack   = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    xfer_abort = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory request registers, wait counter and per-port response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            wait_cnt_reg <= 16'h0;
            if_valid     <= 1'b0;
            ls_valid     <= 1'b0;
            if_rdata     <= 32'h0;
            ls_rdata     <= 32'h0;
            err          <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            err      <= 1'b0;
            if (if_gnt) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'h0;
            end else if (ls_gnt) begin
                mem_we    <= ls_we;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
            end
            if (if_gnt || ls_gnt) begin
                wait_cnt_reg <= 16'h0;
            end else if (in_xfer && !mem_ack) begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
            if (xfer_ack || xfer_abort) begin
                err <= xfer_abort;
                if (state_reg == XFER_LS) begin
                    ls_rdata <= result_data;
                    ls_valid <= 1'b1;
                end else begin
                    if_rdata <= result_data;
                    if_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Expected
// transfers are queued when stimulus is driven and retired on valid pulses.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        if_gnt, if_valid, ls_gnt, ls_valid, mem_req, mem_we, busy, err;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

    typedef struct {
        bit          ls;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          req_cnt = 0;
    int          resp_delay = -1;
    logic [31:0] resp_data = 32'h0;
    bit          stray_ack = 1'b0;
    bit          prev_req = 1'b0;
    logic [31:0] m_if = 32'h0;
    logic [31:0] m_ls = 32'h0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input bit ls, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int delay);
        exp_t e;
        e.ls    = ls;
        e.we    = ls && we;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = (delay < 0);
        e.rdata = (delay < 0) ? 32'hDEAD_BEEF : rdata;
        e.lat   = (delay < 0) ? TO : delay + 1;
        return e;
    endfunction

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder and output monitor
    initial forever begin
        @(negedge clk);
        if (mem_req) req_cnt++;
        else req_cnt = 0;
        mem_ack   = stray_ack || (mem_req && resp_delay >= 0 && req_cnt == resp_delay + 1);
        mem_rdata = mem_ack ? resp_data : 32'h0BAD_0BAD;

        if (mem_req && !prev_req) begin
            rise_cyc = cyc;
            if (sb.size() == 0) check("mem_req_unexpected", 32'd1, 32'd0);
            else begin
                check("mem_addr", mem_addr, sb[0].addr);
                check("mem_we", 32'(mem_we), 32'(sb[0].we));
                if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
                check("busy_xfer", 32'(busy), 32'd1);
            end
        end
        prev_req = mem_req;

        if (if_gnt || ls_gnt) begin
            if (sb.size() == 0) check("gnt_unexpected", 32'd1, 32'd0);
            else check("gnt_port", {30'b0, if_gnt, ls_gnt}, sb[0].ls ? 32'd1 : 32'd2);
            check("busy_idle", 32'(busy), 32'd0);
        end

        if (if_valid || ls_valid) begin
            if (sb.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_port", {30'b0, if_valid, ls_valid}, e.ls ? 32'd1 : 32'd2);
                check("err", 32'(err), 32'(e.err));
                check("latency", 32'(cyc - rise_cyc), 32'(e.lat));
                if (e.ls) m_ls = e.rdata;
                else m_if = e.rdata;
                check("if_rdata", if_rdata, m_if);
                check("ls_rdata", ls_rdata, m_ls);
                $display("xfer %s addr=%h rdata=%h err=%0d lat=%0d",
                         e.ls ? "LS" : "IF", e.addr, e.ls ? ls_rdata : if_rdata, err, cyc - rise_cyc);
            end
        end else if (err) begin
            check("err_stray", 32'd1, 32'd0);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_xfer(input bit ls, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int delay);
        int  waited;
        bit  got;
        @(posedge clk);
        #1;
        sb.push_back(mk(ls, we, addr, wdata, rdata, delay));
        resp_delay = delay;
        resp_data  = rdata;
        if (ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (if_gnt || ls_gnt) got = 1'b1;
            else waited++;
        end
        check("gnt_seen", 32'(got), 32'd1);
        check("gnt_latency", 32'(waited), 32'd0);
        if (got) begin
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        if (!got) sb.delete();
        wait_drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        m_if = 32'h0;
        m_ls = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valids", {30'b0, if_valid, ls_valid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch with ack two cycles after mem_req
        run_xfer(1'b0, 1'b0, 32'h100, 32'h0, 32'hE3A0_0001, 2);
        // Load/store write with ack after one cycle
        run_xfer(1'b1, 1'b1, 32'h2000, 32'h55AA_55AA, 32'hC0FF_EE00, 1);
        // Load/store read acknowledged in the first transfer cycle
        run_xfer(1'b1, 1'b0, 32'h3000, 32'h0, 32'h1111_2222, 0);

        // Stray ack while idle must be ignored
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        #1;
        check("stray_ack_busy", 32'(busy), 32'd0);

        // Timeout abort
        run_xfer(1'b1, 1'b0, 32'h4000, 32'h0, 32'h0000_0077, -1);
        // Ack in the same cycle as the timeout wins
        run_xfer(1'b0, 1'b0, 32'h500, 32'h0, 32'h600D_F00D, TO - 1);

        // Both ports requesting for four transfers after reset
        do_reset();
        @(posedge clk);
        #1;
        resp_delay = 1;
        resp_data  = 32'h1357_2468;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            bit ls_turn = (k % 2) == 1;
`else
            bit ls_turn = 1'b1;
`endif
            sb.push_back(mk(ls_turn, 1'b0, ls_turn ? 32'h400 : 32'h300, 32'h0, 32'h1357_2468, 1));
        end
        if_addr = 32'h300; ls_addr = 32'h400; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        g = 0;
        for (int i = 0; i < 100 && g < 4; i++) begin
            @(negedge clk);
            #1;
            if (if_gnt || ls_gnt) g++;
        end
        check("arb_grants", 32'(g), 32'd4);
        @(posedge clk);
        #1;
        if_req = 1'b0; ls_req = 1'b0;
        wait_drain();

        // Reset during a fetch transfer
        do_reset();
        @(posedge clk);
        #1;
        sb.push_back(mk(1'b0, 1'b0, 32'h700, 32'h0, 32'h0, -1));
        resp_delay = -1;
        if_addr = 32'h700;
        if_req = 1'b1;
        g = 0;
        for (int i = 0; i < 20 && g == 0; i++) begin
            @(negedge clk);
            #1;
            if (if_gnt) g = 1;
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        check("rst_mid_in_xfer", 32'(mem_req), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        sb.delete();
        m_if = 32'h0;
        m_ls = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_xfer(1'b0, 1'b0, 32'h800, 32'h0, 32'hABCD_0123, 2);

        @(negedge clk);
        #1;
        check("final_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
